ex_mc_ctrl: RTL and testbench
=============================

Name: ex_mc_ctrl

Overview:
Sequencer for the multi-cycle functional units in the EX stage, such as the carry-less multiplier and an iterative divider. Only one unit runs at a time.
- Issues a start pulse to the selected unit and holds the pipeline via stall_req while the unit runs.
- Captures the unit result and holds it until the pipeline advances.
- Aborts the unit on flush or timeout.
- Sits between EX decode (req_valid/req_unit), the hazard/stall logic (ext_stall, flush) and the unit instances.

Parameters:
NUNITS, 2, number of attached multi-cycle units
W, 32, result width
TIMEOUT, 64, max RUN cycles (counted while not ext_stall) before abort and trap
UW, $clog2(NUNITS) (min 1), width of the unit index

Ports:
clk  input  1  clock
reset_n  input  1  reset, synchronous, active-low
req_valid  input  1  instruction in EX needs a multi-cycle unit; held until it leaves EX
req_unit  input  UW  index of the requested unit; stable while req_valid
ext_stall  input  1  pipeline frozen by another source; also routed directly to the units
flush  input  1  kill the instruction in EX
unit_start  output  NUNITS  one-cycle start pulse, one-hot
unit_abort  output  NUNITS  one-cycle abort pulse, one-hot
unit_done  input  NUNITS  per-unit completion, valid in the cycle it is high
unit_res  input  NUNITS*W  per-unit results; slice i = unit_res[i*W +: W]
stall_req  output  1  hold the pipeline
res  output  W  captured result
res_valid  output  1  res valid for the instruction in EX
timeout_trap  output  1  unit timed out; res forced to 0
busy  output  1  state != IDLE

Behaviour:
- Reset: state=IDLE, sel=0, cnt=0, res=0, trap_q=0.
  - All outputs 0 during and after reset.
  - No abort pulse on reset (units share reset_n).
  - Reset mid-RUN returns to IDLE next edge; any in-flight done is ignored.
- States: IDLE, RUN, DONE. Registers: sel (UW bits), cnt ($clog2(TIMEOUT+1) bits), res, trap_q.
- IDLE:
  - unit_start[req_unit] = req_valid && !flush && !ext_stall (combinational).
  - On start: sel<=req_unit, cnt<=0, trap_q<=0, go to RUN.
  - req_valid under ext_stall: no start, remain IDLE.
- RUN:
  - If !ext_stall, cnt<=cnt+1. cnt is frozen under ext_stall.
  - unit_done[sel]=1: res<=slice sel, go to DONE. Captured even if ext_stall=1.
  - cnt==TIMEOUT-1 && !ext_stall && !unit_done[sel]: unit_abort[sel] pulse, res<=0, trap_q<=1, go to DONE.
  - unit_done of a non-selected unit is ignored in every state. unit_done in IDLE/DONE is ignored.
- DONE:
  - res_valid=1; timeout_trap=trap_q.
  - Stay while ext_stall=1. Go to IDLE on the first cycle with ext_stall=0, when the instruction leaves EX.
- flush:
  - Highest priority in every state, above done and timeout in the same cycle.
  - RUN: unit_abort[sel] pulse, go to IDLE, res not updated, res_valid never asserted.
  - DONE: go to IDLE.
  - IDLE: suppress start.
- stall_req = req_valid && !flush && (state==IDLE || state==RUN).
  - stall_req is 0 in DONE, so EX consumes res.
  - stall_req is independent of ext_stall.
- Latency: start issued in cycle 0.
  - If the unit raises done in cycle k (k>=1), the controller is in DONE from cycle k+1.
  - stall_req is high for cycles 0..k.
- Back-to-back: DONE→IDLE and the next start follow without bubbles beyond the single IDLE start cycle.
- At most one bit of unit_start and of unit_abort is high in any cycle. Both are never high in the same cycle.

Test Plan:
- Basic: req_valid=1, req_unit=0, done[0] in cycle 3 with res=32'hDEADBEEF → start[0] in cycle 0, stall_req high cycles 0-3, res_valid=1 and res=DEADBEEF in cycle 4, IDLE in cycle 5.
- Ext stall: same as basic with ext_stall=1 during cycles 4-6 → state stays DONE, res_valid held through cycle 6, IDLE in cycle 8; second case with ext_stall high at request time → no start until ext_stall drops.
- Wrong unit: sel=1, done[0] pulse in cycle 2, done[1] in cycle 5 with res=5 → done[0] ignored, res=5 from cycle 6.
- Timeout: TIMEOUT=8, no done → abort[sel] in cycle 8, then DONE with res=0, timeout_trap=1; with ext_stall pulses in RUN, the abort is delayed by the stalled cycles.
- Flush: flush=1 in cycle 2 of RUN together with done[sel] → abort[sel] pulse, IDLE next edge, res_valid stays 0, res unchanged.
- Reset: reset_n=0 for 1 cycle in mid-RUN → IDLE, all outputs 0, no abort pulse; a new request afterwards starts normally.

Source files
------------

// File: rtl/ex_mc_if.sv
// Bundle between EX decode, the hazard logic, the multi-cycle units and the sequencer.
// The slave modport is the sequencer's view; master is the surrounding pipeline/unit side.
interface ex_mc_if #(
    parameter int NUNITS = 2,
    parameter int W      = 32,
    parameter int UW     = (NUNITS > 1) ? $clog2(NUNITS) : 1
);
    logic                  req_valid;
    logic [UW-1:0]         req_unit;
    logic                  ext_stall;
    logic                  flush;
    logic [NUNITS-1:0]     unit_start;
    logic [NUNITS-1:0]     unit_abort;
    logic [NUNITS-1:0]     unit_done;
    logic [NUNITS*W-1:0]   unit_res;
    logic                  stall_req;
    logic [W-1:0]          res;
    logic                  res_valid;
    logic                  timeout_trap;
    logic                  busy;

    modport slave (
        input  req_valid, req_unit, ext_stall, flush, unit_done, unit_res,
        output unit_start, unit_abort, stall_req, res, res_valid, timeout_trap, busy
    );

    modport master (
        output req_valid, req_unit, ext_stall, flush, unit_done, unit_res,
        input  unit_start, unit_abort, stall_req, res, res_valid, timeout_trap, busy
    );
endinterface

// File: rtl/ex_mc_ctrl.sv
// EX-stage sequencer for multi-cycle units: starts one unit, stalls the pipe while it runs,
// captures its result, and aborts it on flush or after TIMEOUT unstalled run cycles.
module ex_mc_ctrl #(
    parameter int NUNITS  = 2,
    parameter int W       = 32,
    parameter int TIMEOUT = 64,
    parameter int UW      = (NUNITS > 1) ? $clog2(NUNITS) : 1
) (
    input  logic     clk,
    input  logic     reset_n,
    ex_mc_if.slave   bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [UW-1:0]      sel_q, sel_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [W-1:0]       res_q, res_d;
    logic               trap_q, trap_d;
    logic [NUNITS-1:0]  start_vec, abort_vec;
    logic               sel_done;
    logic [W-1:0]       sel_res;

    assign sel_done = bus.unit_done[sel_q];
    assign sel_res  = bus.unit_res[sel_q*W +: W];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        trap_d    = trap_q;
        start_vec = '0;
        abort_vec = '0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && !bus.flush && !bus.ext_stall) begin
                    start_vec = NUNITS'(1) << bus.req_unit;
                    sel_d     = bus.req_unit;
                    cnt_d     = '0;
                    trap_d    = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Flush beats a same-cycle done or timeout; a done beats a same-cycle timeout.
                if (bus.flush) begin
                    abort_vec = NUNITS'(1) << sel_q;
                    state_d   = IDLE;
                end else if (sel_done) begin
                    res_d   = sel_res;
                    state_d = DONE;
                end else if (!bus.ext_stall && cnt_q == CW'(TIMEOUT - 1)) begin
                    abort_vec = NUNITS'(1) << sel_q;
                    res_d     = '0;
                    trap_d    = 1'b1;
                    state_d   = DONE;
                end else if (!bus.ext_stall) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.flush || !bus.ext_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is held at zero while reset is asserted, including mid-run aborts.
    assign bus.unit_start   = reset_n ? start_vec : '0;
    assign bus.unit_abort   = reset_n ? abort_vec : '0;
    assign bus.stall_req    = reset_n && bus.req_valid && !bus.flush && (state_q != DONE);
    assign bus.res          = reset_n ? res_q : '0;
    assign bus.res_valid    = reset_n && (state_q == DONE);
    assign bus.timeout_trap = reset_n && (state_q == DONE) && trap_q;
    assign bus.busy         = reset_n && (state_q != IDLE);
endmodule

// File: tb/tb_ex_mc_ctrl.sv
// Directed bench for ex_mc_ctrl: inputs change 1ns after posedge, outputs sampled on negedge,
// captured results checked against a queue filled when the unit response is driven.
module tb_ex_mc_ctrl;
    localparam int NUNITS = 2;
    localparam int W      = 32;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    logic [32:0] exp_q[$];
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    ex_mc_if #(.NUNITS(NUNITS), .W(W)) bus ();

    ex_mc_ctrl #(.NUNITS(NUNITS), .W(W), .TIMEOUT(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic trap, input logic [31:0] val);
        exp_q.push_back({trap, val});
        last_res = val;
    endtask

    // Called in the first DONE cycle: compares the captured result with the oldest expectation.
    task automatic expect_result();
        logic [32:0] e;
        chk("res_valid", bus.res_valid, 1);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("res", bus.res, e[31:0]);
            chk("trap", bus.timeout_trap, e[32]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_start"}, bus.unit_start, 0);
        chk({tag, "_abort"}, bus.unit_abort, 0);
        chk({tag, "_stall"}, bus.stall_req, 0);
        chk({tag, "_res"}, bus.res, 0);
        chk({tag, "_rv"}, bus.res_valid, 0);
        chk({tag, "_trap"}, bus.timeout_trap, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    // Request 'unit', done in cycle k; optionally keep req_valid high for a back-to-back request.
    task automatic simple(input int unit, input int k, input logic [31:0] val, input bit keep);
        next();
        bus.req_valid = 1; bus.req_unit = 1'(unit); bus.ext_stall = 0; bus.unit_done = '0;
        @(negedge clk);
        chk("start", bus.unit_start, 64'(1) << unit);
        chk("stall_c0", bus.stall_req, 1);
        for (int c = 1; c <= k; c++) begin
            next();
            if (c == k) begin
                bus.unit_done = 2'(1) << unit;
                bus.unit_res[unit*W +: W] = val;
                push(0, val);
            end
            @(negedge clk);
            chk("stall_run", bus.stall_req, 1);
            chk("busy_run", bus.busy, 1);
            chk("start_run", bus.unit_start, 0);
        end
        next();
        bus.unit_done = '0;
        @(negedge clk);
        expect_result();
        chk("stall_done", bus.stall_req, 0);
        if (!keep) begin
            next();
            bus.req_valid = 0;
            @(negedge clk);
            chk("busy_after", bus.busy, 0);
            chk("rv_after", bus.res_valid, 0);
        end
    endtask

    // No done ever arrives; ext_stall is raised in run cycles sa and sb (0 = unused).
    task automatic timeout_case(input int sa, input int sb, input int abort_cyc);
        next();
        bus.req_valid = 1; bus.req_unit = 1'b1; bus.ext_stall = 0;
        push(1, 32'h0);
        @(negedge clk);
        chk("to_start", bus.unit_start, 2'b10);
        for (int c = 1; c <= abort_cyc; c++) begin
            next();
            bus.ext_stall = (c == sa || c == sb);
            @(negedge clk);
            chk("to_abort", bus.unit_abort, (c == abort_cyc) ? 2'b10 : 2'b00);
            chk("to_rv", bus.res_valid, 0);
        end
        next();
        bus.ext_stall = 0;
        @(negedge clk);
        expect_result();
        next();
        bus.req_valid = 0;
        @(negedge clk);
        chk("to_idle", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0;
        bus.req_valid = 0; bus.req_unit = '0; bus.ext_stall = 0; bus.flush = 0;
        bus.unit_done = '0; bus.unit_res = '0;
        next();
        @(negedge clk);
        check_idle_outputs("rst");
        next();
        reset_n = 1;
        @(negedge clk);
        check_idle_outputs("post_rst");

        // Basic unit 0, done in cycle 3.
        simple(0, 3, 32'hDEADBEEF, 0);

        // DONE held by ext_stall in cycles 4-6, IDLE in cycle 8.
        next();
        bus.req_valid = 1; bus.req_unit = 1'b0;
        @(negedge clk);
        chk("es_start", bus.unit_start, 2'b01);
        for (int c = 1; c <= 8; c++) begin
            next();
            bus.unit_done = (c == 3) ? 2'b01 : 2'b00;
            if (c == 3) begin
                bus.unit_res[31:0] = 32'h0BADF00D;
                push(0, 32'h0BADF00D);
            end
            bus.ext_stall = (c >= 4 && c <= 6);
            if (c == 8) bus.req_valid = 0;
            @(negedge clk);
            if (c == 4) expect_result();
            if (c >= 5 && c <= 7) chk("es_hold_rv", bus.res_valid, 1);
            if (c == 8) chk("es_idle", bus.busy, 0);
        end

        // Request under ext_stall: no start until it drops.
        next();
        bus.req_valid = 1; bus.req_unit = 1'b1; bus.ext_stall = 1;
        @(negedge clk);
        chk("esr_nostart", bus.unit_start, 0);
        chk("esr_stall", bus.stall_req, 1);
        next();
        @(negedge clk);
        chk("esr_nostart2", bus.unit_start, 0);
        chk("esr_busy", bus.busy, 0);
        simple(1, 1, 32'h0000_00A5, 0);

        // Done from the non-selected unit is ignored.
        next();
        bus.req_valid = 1; bus.req_unit = 1'b1;
        @(negedge clk);
        chk("wu_start", bus.unit_start, 2'b10);
        for (int c = 1; c <= 5; c++) begin
            next();
            bus.unit_done = (c == 2) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00;
            bus.unit_res = {32'd5, 32'h1111_1111};
            if (c == 5) push(0, 32'd5);
            @(negedge clk);
            chk("wu_rv", bus.res_valid, 0);
        end
        next();
        bus.unit_done = '0;
        @(negedge clk);
        expect_result();
        next();
        bus.req_valid = 0;
        @(negedge clk);

        // Timeout: plain, then delayed by two stalled run cycles.
        timeout_case(0, 0, 8);
        timeout_case(3, 5, 10);

        // Back-to-back: second start in the cycle after DONE.
        simple(0, 2, 32'h1357_9BDF, 1);
        simple(1, 1, 32'h2468_ACE0, 0);

        // Flush in run cycle 2 together with done.
        next();
        bus.req_valid = 1; bus.req_unit = 1'b1;
        @(negedge clk);
        next();
        @(negedge clk);
        next();
        bus.flush = 1; bus.unit_done = 2'b10; bus.unit_res = {32'hBAD0_BAD0, 32'h0};
        @(negedge clk);
        chk("fl_abort", bus.unit_abort, 2'b10);
        chk("fl_stall", bus.stall_req, 0);
        chk("fl_rv", bus.res_valid, 0);
        next();
        bus.flush = 0; bus.unit_done = '0; bus.req_valid = 0;
        @(negedge clk);
        chk("fl_idle", bus.busy, 0);
        chk("fl_rv2", bus.res_valid, 0);
        chk("fl_res", bus.res, last_res);

        // Reset mid-run with an in-flight done.
        next();
        bus.req_valid = 1; bus.req_unit = 1'b0;
        @(negedge clk);
        next();
        @(negedge clk);
        next();
        reset_n = 0; bus.unit_done = 2'b01; bus.unit_res = {32'h0, 32'hFFFF_0000};
        bus.req_valid = 0;
        @(negedge clk);
        check_idle_outputs("mid_rst");
        next();
        reset_n = 1; bus.unit_done = '0;
        @(negedge clk);
        check_idle_outputs("after_rst");
        simple(0, 2, 32'h1234_5678, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
